// File: rtl/shifter_pkg.sv
// Shared shifter package: stage-count helper, default widths and the per-stage record.
// Used by the left shifter pipe and the companion right shifter.
package shifter_pkg;

  function automatic int unsigned clog2_f(input int unsigned n);
    return $clog2(n);
  endfunction

  localparam int unsigned LshDefaultN = 8;
  localparam int unsigned LshDefaultL = clog2_f(LshDefaultN);

  // Constants shared with the right-shift companion block
  localparam int unsigned RshDefaultN = 8;
  localparam int unsigned RshDefaultL = clog2_f(RshDefaultN);
  localparam int unsigned RshMaxN     = 64;

  // Per-stage record at default width; modules re-declare it for their own N
  typedef struct packed {
    logic                   valid;
    logic [LshDefaultN-1:0] data;
    logic [LshDefaultL-1:0] amt;
    logic                   ovf;
  } lsh_stage_t;

endpackage

// File: rtl/left_shift_stage.sv
// Combinational single-weight left shift stage. Logical shift with discard detection,
// or rotate when SHIFTER_ROTATE_EN is defined (ovf_o then tied low).
module left_shift_stage #(
  parameter int unsigned N     = 8,
  parameter int unsigned SHIFT = 1
) (
  input  logic [N-1:0] data_i,
  input  logic         en_i,
  output logic [N-1:0] data_o,
  output logic         ovf_o
);

  logic [N-1:0] shifted;

`ifdef SHIFTER_ROTATE_EN
  always_comb begin
    shifted = {data_i[N-SHIFT-1:0], data_i[N-1 -: SHIFT]};
    ovf_o   = 1'b0;
  end
`else
  always_comb begin
    shifted = {data_i[N-SHIFT-1:0], {SHIFT{1'b0}}};
    ovf_o   = en_i & (|data_i[N-1 -: SHIFT]);
  end
`endif

  assign data_o = en_i ? shifted : data_i;

endmodule

// File: rtl/param_left_shifter_pipe.sv
// Pipelined left barrel shifter: capture stage plus one registered stage per binary weight,
// global stall handshake. SHIFTER_ROTATE_EN selects rotate instead of logical shift.
module param_left_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int unsigned N = LshDefaultN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          x,
  input  logic [clog2_f(N)-1:0] amt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          z,
  output logic                  ovf
);

  localparam int unsigned L = clog2_f(N);

  typedef struct packed {
    logic         valid;
    logic [N-1:0] data;
    logic [L-1:0] amt;
    logic         ovf;
  } stage_t;

  // Entry 0 captures the raw operand; entry k+1 holds the result after weight 2^k.
  stage_t       stage_q [L+1];
  stage_t       stage_d [L+1];
  logic [N-1:0] sh_data [L];
  logic         sh_ovf  [L];
  logic         en;

  for (genvar k = 0; k < L; k++) begin : g_stage
    left_shift_stage #(
      .N    (N),
      .SHIFT(int'(1) << k)
    ) u_stage (
      .data_i(stage_q[k].data),
      .en_i  (stage_q[k].amt[k]),
      .data_o(sh_data[k]),
      .ovf_o (sh_ovf[k])
    );
  end

  always_comb begin
    en = !stage_q[L].valid || out_ready;
  end

  always_comb begin
    stage_d[0].valid = in_valid;
    stage_d[0].data  = x;
    stage_d[0].amt   = amt;
    stage_d[0].ovf   = 1'b0;
    for (int k = 0; k < int'(L); k++) begin
      stage_d[k+1].valid = stage_q[k].valid;
      stage_d[k+1].data  = sh_data[k];
      stage_d[k+1].amt   = stage_q[k].amt;
      stage_d[k+1].ovf   = stage_q[k].ovf | sh_ovf[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= int'(L); k++) begin
        stage_q[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k <= int'(L); k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  always_comb begin
    in_ready  = en;
    out_valid = stage_q[L].valid;
    z         = stage_q[L].data;
    ovf       = stage_q[L].ovf;
  end

  a_hold_on_stall: assert property (@(posedge clk) disable iff (!reset_n)
    out_valid && !out_ready |=> out_valid && $stable(z) && $stable(ovf));

  a_ready_is_en: assert property (@(posedge clk) disable iff (!reset_n)
    in_ready == (!out_valid || out_ready));

endmodule

// File: tb/tb_param_left_shifter_pipe.sv
// Self-checking bench for param_left_shifter_pipe (N=8) against a wide-arithmetic model.
module tb_param_left_shifter_pipe;

  localparam int unsigned N = 8;
  localparam int unsigned L = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [L-1:0] amt;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] z;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  param_left_shifter_pipe #(.N(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .amt      (amt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .z        (z),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ref_z(input logic [N-1:0] a, input logic [L-1:0] s);
    logic [2*N-1:0] full;
    full = {{N{1'b0}}, a} << s;
`ifdef SHIFTER_ROTATE_EN
    return full[N-1:0] | full[2*N-1:N];
`else
    return full[N-1:0];
`endif
  endfunction

  function automatic logic ref_ovf(input logic [N-1:0] a, input logic [L-1:0] s);
    logic [2*N-1:0] full;
    full = {{N{1'b0}}, a} << s;
`ifdef SHIFTER_ROTATE_EN
    return 1'b0 & full[0];
`else
    return |full[2*N-1:N];
`endif
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; amt = '0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (z !== '0) begin errors++; $display("FAIL reset_z: got %h want 00", z); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [N-1:0] tx [3];
    logic [L-1:0] ta [3];
    logic [N-1:0] tz [3];
    logic         to [3];
    tx = '{8'h96, 8'h5A, 8'h01};
    ta = '{3'd3, 3'd0, 3'd7};
`ifdef SHIFTER_ROTATE_EN
    tz = '{8'hB4, 8'h5A, 8'h80};
    to = '{1'b0, 1'b0, 1'b0};
`else
    tz = '{8'hB0, 8'h5A, 8'h80};
    to = '{1'b1, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = tx[i]; amt = ta[i]; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_in_ready[%0d]: got %b want 1", i, in_ready); end
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c <= int'(L); c++) begin
        if (c > 0) begin @(posedge clk); @(negedge clk); end
        checks++;
        if (out_valid !== (c == int'(L))) begin
          errors++; $display("FAIL dir_latency[%0d] cyc %0d: got out_valid=%b", i, c, out_valid);
        end
        if (c == int'(L)) begin
          checks++; if (z !== tz[i]) begin errors++; $display("FAIL dir_z[%0d]: got %h want %h", i, z, tz[i]); end
          checks++; if (ovf !== to[i]) begin errors++; $display("FAIL dir_ovf[%0d]: got %b want %b", i, ovf, to[i]); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] bx [16];
    logic [L-1:0] ba [16];
    int k;
    for (int i = 0; i < 16; i++) begin
      bx[i] = N'($urandom);
      ba[i] = L'($urandom_range(0, N-1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 16 + int'(L) + 1; c++) begin
      if (c < 16) begin in_valid = 1'b1; x = bx[c]; amt = ba[c]; end
      else in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc %0d: got %b want 1", c, in_ready); end
      @(posedge clk); @(negedge clk);
      k = c - int'(L);
      checks++;
      if (out_valid !== (k >= 0 && k < 16)) begin
        errors++; $display("FAIL b2b_valid cyc %0d: got %b", c, out_valid);
      end
      if (k >= 0 && k < 16) begin
        checks++;
        if (z !== ref_z(bx[k], ba[k]) || ovf !== ref_ovf(bx[k], ba[k])) begin
          errors++; $display("FAIL b2b_data[%0d]: got z=%h ovf=%b want z=%h ovf=%b",
                             k, z, ovf, ref_z(bx[k], ba[k]), ref_ovf(bx[k], ba[k]));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] sx [12];
    logic [L-1:0] sa [12];
    logic [N-1:0] qz [$];
    logic         qo [$];
    logic [N-1:0] held;
    int nxt = 0;
    int popped = 0;
    held = '0;
    for (int i = 0; i < 12; i++) begin
      sx[i] = N'($urandom);
      sa[i] = L'($urandom_range(0, N-1));
    end
    @(negedge clk);
    for (int c = 0; c < 40 && popped < 12; c++) begin
      out_ready = !(c >= 6 && c < 10);
      if (nxt < 12) begin in_valid = 1'b1; x = sx[nxt]; amt = sa[nxt]; end
      else in_valid = 1'b0;
      #1;
      if (out_ready) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_hi cyc %0d: got %b want 1", c, in_ready); end
      end
      if (c == 6) held = z;
      if (c >= 6 && c < 10) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d: got %b want 0", c, in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid cyc %0d: got %b want 1", c, out_valid); end
        if (c > 6) begin
          checks++; if (z !== held) begin errors++; $display("FAIL stall_z_stable cyc %0d: got %h want %h", c, z, held); end
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (qz.size() == 0) begin
          errors++; $display("FAIL stall_extra_output cyc %0d: got z=%h want none", c, z);
        end else begin
          if (z !== qz[0] || ovf !== qo[0]) begin
            errors++; $display("FAIL stall_data[%0d]: got z=%h ovf=%b want z=%h ovf=%b",
                               popped, z, ovf, qz[0], qo[0]);
          end
          void'(qz.pop_front()); void'(qo.pop_front());
        end
        popped++;
      end
      if (in_valid && in_ready) begin
        qz.push_back(ref_z(sx[nxt], sa[nxt]));
        qo.push_back(ref_ovf(sx[nxt], sa[nxt]));
        nxt++;
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (popped !== 12 || nxt !== 12) begin errors++; $display("FAIL stall_count: got popped=%0d pushed=%0d want 12", popped, nxt); end
  endtask

  task automatic test_toggle();
    logic         hist [40];
    logic [N-1:0] qz [$];
    int k;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) hist[c] = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 24; c++) begin
      k = c - int'(L) - 1;
      checks++;
      if (out_valid !== (k >= 0 && hist[k])) begin
        errors++; $display("FAIL toggle_valid cyc %0d: got %b want %b", c, out_valid, k >= 0 && hist[k]);
      end
      if (out_valid && qz.size() > 0) begin
        checks++; if (z !== qz[0]) begin errors++; $display("FAIL toggle_z cyc %0d: got %h want %h", c, z, qz[0]); end
        void'(qz.pop_front());
      end
      in_valid = (c % 2 == 0) && (c < 16);
      x = N'($urandom); amt = L'($urandom_range(0, N-1));
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL toggle_in_ready cyc %0d: got %b want 1", c, in_ready); end
      if (in_valid) begin hist[c] = 1'b1; qz.push_back(ref_z(x, amt)); end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x = N'($urandom) | 8'h01; amt = L'($urandom_range(1, N-1));
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
    checks++; if (z !== '0) begin errors++; $display("FAIL rmid_z: got %h want 00", z); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    in_valid = 1'b1; x = 8'h0F; amt = 3'd4;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c <= int'(L); c++) begin
      if (c > 0) begin @(posedge clk); @(negedge clk); end
      checks++;
      if (out_valid !== (c == int'(L))) begin
        errors++; $display("FAIL rmid_latency cyc %0d: got out_valid=%b", c, out_valid);
      end
    end
    checks++; if (z !== 8'hF0) begin errors++; $display("FAIL rmid_z_after: got %h want f0", z); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rmid_ovf_after: got %b want 0", ovf); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_toggle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
